// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the TX FIFO: round-robin between a 2-byte ALU result
// and a 1-byte register-file result, serialised onto the FIFO write port.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ALU_VLD,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  output logic                      ALU_RDY,
  input  logic                      RF_VLD,
  input  logic [DATA_WIDTH-1:0]     RF_DATA,
  output logic                      RF_RDY,
  input  logic                      FULL,
  output logic [DATA_WIDTH-1:0]     WR_DATA,
  output logic                      W_INC,
  output logic                      BUSY,
  output logic [CNT_WIDTH-1:0]      WR_CNT,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    WR_RF = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [2*DATA_WIDTH-1:0] hold;
  logic                    last;
  logic                    grant_alu;
  logic                    grant_rf;

  // Handshake: a producer raises VLD with stable data and holds it until its
  // RDY pulse; RDY is high for the one cycle after the capture edge, and VLD is
  // only looked at in IDLE, so the producer may drop or replace it during RDY.
  always_comb begin
    grant_alu = 1'b0;
    grant_rf  = 1'b0;
    if (state == IDLE) begin
      grant_alu = ALU_VLD && (!RF_VLD || last);
      grant_rf  = RF_VLD && (!ALU_VLD || !last);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_alu) begin
          state_nxt = WR_LO;
        end else if (grant_rf) begin
          state_nxt = WR_RF;
        end
      end
      WR_LO:   if (W_INC) state_nxt = WR_HI;
      WR_HI:   if (W_INC) state_nxt = IDLE;
      WR_RF:   if (W_INC) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FULL gates the write in the same cycle; state and data simply hold.
  always_comb begin
    W_INC   = 1'b0;
    WR_DATA = '0;
    case (state)
      WR_LO, WR_RF: begin
        W_INC   = !FULL;
        WR_DATA = hold[DATA_WIDTH-1:0];
      end
      WR_HI: begin
        W_INC   = !FULL;
        WR_DATA = hold[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      default: begin
        W_INC   = 1'b0;
        WR_DATA = '0;
      end
    endcase
    BUSY      = (state != IDLE);
    state_dbg = state;
  end

  // last resets to 1 so the ALU wins the first tie after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold    <= '0;
      last    <= 1'b1;
      ALU_RDY <= 1'b0;
      RF_RDY  <= 1'b0;
    end else begin
      ALU_RDY <= grant_alu;
      RF_RDY  <= grant_rf;
      if (grant_alu) begin
        hold <= ALU_OUT;
        last <= 1'b0;
      end else if (grant_rf) begin
        hold <= {{DATA_WIDTH{1'b0}}, RF_DATA};
        last <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WR_CNT <= '0;
    end else if (W_INC) begin
      WR_CNT <= WR_CNT + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-scenario tasks with inline checks and
// a byte scoreboard fed by a monitor on the FIFO write port.
module tb_fifo_wr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_RDY;
  logic        RF_VLD;
  logic [7:0]  RF_DATA;
  logic        RF_RDY;
  logic        FULL;
  logic [7:0]  WR_DATA;
  logic        W_INC;
  logic        BUSY;
  logic [7:0]  WR_CNT;
  logic [1:0]  state_dbg;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_cnt;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_VLD(ALU_VLD), .ALU_OUT(ALU_OUT), .ALU_RDY(ALU_RDY),
    .RF_VLD(RF_VLD), .RF_DATA(RF_DATA), .RF_RDY(RF_RDY),
    .FULL(FULL), .WR_DATA(WR_DATA), .W_INC(W_INC),
    .BUSY(BUSY), .WR_CNT(WR_CNT), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // inputs only change 2ns after a rising edge, so the negedge value of
  // W_INC is exactly what the next rising edge commits to the FIFO
  always @(negedge CLK) begin
    if (W_INC) got_q.push_back(WR_DATA);
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset;
    RST = 1'b1; ALU_VLD = 1'b0; ALU_OUT = '0; RF_VLD = 1'b0; RF_DATA = '0; FULL = 1'b0;
    exp_cnt = 8'd0;
    #3;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, BUSY} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl act=%b exp=0000", {ALU_RDY, RF_RDY, W_INC, BUSY});
    end
    checks++;
    if ({WR_DATA, WR_CNT, state_dbg} !== 18'd0) begin
      failures++; $display("FAIL reset_data act=%h/%h/%0d exp=0/0/0", WR_DATA, WR_CNT, state_dbg);
    end
    tick; tick;
    RST = 1'b0;
  endtask

  task automatic test_tie;
    logic [8:1] a_exp;
    logic [8:1] r_exp;
    a_exp = 8'b0010_0001;
    r_exp = 8'b0000_1000;
    ALU_OUT = 16'h1234; RF_DATA = 8'h77; ALU_VLD = 1'b1; RF_VLD = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (i == 7) begin ALU_VLD = 1'b0; RF_VLD = 1'b0; end
      #1;
      checks++;
      if ({ALU_RDY, RF_RDY} !== {a_exp[i], r_exp[i]}) begin
        failures++; $display("FAIL tie_grant cyc=%0d act=%b exp=%b", i, {ALU_RDY, RF_RDY}, {a_exp[i], r_exp[i]});
      end
    end
    exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'h77);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_cnt = exp_cnt + 8'd5;
    checks++;
    if ({BUSY, WR_CNT} !== {1'b0, exp_cnt}) begin
      failures++; $display("FAIL tie_end act=%b/%0d exp=0/%0d", BUSY, WR_CNT, exp_cnt);
    end
  endtask

  task automatic test_rf;
    RF_VLD = 1'b1; RF_DATA = 8'h5A;
    tick; RF_VLD = 1'b0; #1;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, BUSY, WR_DATA, WR_CNT} !== {4'b0111, 8'h5A, exp_cnt}) begin
      failures++; $display("FAIL rf_write act=%b/%h/%0d exp=0111/5a/%0d", {ALU_RDY, RF_RDY, W_INC, BUSY}, WR_DATA, WR_CNT, exp_cnt);
    end
    exp_q.push_back(8'h5A); exp_cnt = exp_cnt + 8'd1;
    tick; #1;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, BUSY, WR_DATA, WR_CNT} !== {4'b0000, 8'h00, exp_cnt}) begin
      failures++; $display("FAIL rf_idle act=%b/%h/%0d exp=0000/00/%0d", {ALU_RDY, RF_RDY, W_INC, BUSY}, WR_DATA, WR_CNT, exp_cnt);
    end
  endtask

  task automatic test_alu;
    ALU_VLD = 1'b1; ALU_OUT = 16'hBEEF;
    tick; ALU_VLD = 1'b0; #1;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, BUSY, WR_DATA} !== {4'b1011, 8'hEF}) begin
      failures++; $display("FAIL alu_lo act=%b/%h exp=1011/ef", {ALU_RDY, RF_RDY, W_INC, BUSY}, WR_DATA);
    end
    tick; #1;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, BUSY, WR_DATA} !== {4'b0011, 8'hBE}) begin
      failures++; $display("FAIL alu_hi act=%b/%h exp=0011/be", {ALU_RDY, RF_RDY, W_INC, BUSY}, WR_DATA);
    end
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_cnt = exp_cnt + 8'd2;
    tick; #1;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, BUSY, WR_CNT} !== {4'b0000, exp_cnt}) begin
      failures++; $display("FAIL alu_done act=%b/%0d exp=0000/%0d", {ALU_RDY, RF_RDY, W_INC, BUSY}, WR_CNT, exp_cnt);
    end
  endtask

  task automatic test_full;
    ALU_VLD = 1'b1; ALU_OUT = 16'hA55A;
    tick; ALU_VLD = 1'b0; #1;
    checks++;
    if ({ALU_RDY, W_INC, WR_DATA} !== {2'b11, 8'h5A}) begin
      failures++; $display("FAIL full_lo act=%b/%h exp=11/5a", {ALU_RDY, W_INC}, WR_DATA);
    end
    exp_q.push_back(8'h5A); exp_cnt = exp_cnt + 8'd1;
    for (int j = 0; j < 5; j++) begin
      tick; FULL = 1'b1; #1;
      checks++;
      if ({W_INC, BUSY, WR_DATA, WR_CNT} !== {2'b01, 8'hA5, exp_cnt}) begin
        failures++; $display("FAIL full_hold cyc=%0d act=%b/%h/%0d exp=01/a5/%0d", j, {W_INC, BUSY}, WR_DATA, WR_CNT, exp_cnt);
      end
    end
    tick; FULL = 1'b0; #1;
    checks++;
    if ({W_INC, BUSY, WR_DATA} !== {2'b11, 8'hA5}) begin
      failures++; $display("FAIL full_resume act=%b/%h exp=11/a5", {W_INC, BUSY}, WR_DATA);
    end
    exp_q.push_back(8'hA5); exp_cnt = exp_cnt + 8'd1;
    tick; #1;
    checks++;
    if ({BUSY, WR_CNT} !== {1'b0, exp_cnt}) begin
      failures++; $display("FAIL full_done act=%b/%0d exp=0/%0d", BUSY, WR_CNT, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    ALU_VLD = 1'b1; ALU_OUT = 16'hC3D2;
    tick; ALU_VLD = 1'b0; #1;
    exp_q.push_back(8'hD2);
    tick; #1;
    checks++;
    if ({W_INC, BUSY, state_dbg, WR_DATA} !== {2'b11, 2'd2, 8'hC3}) begin
      failures++; $display("FAIL mid_hi act=%b/%0d/%h exp=11/2/c3", {W_INC, BUSY}, state_dbg, WR_DATA);
    end
    RST = 1'b1; #1;
    exp_cnt = 8'd0;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, BUSY, WR_DATA, WR_CNT, state_dbg} !== {4'b0000, 8'h00, 8'h00, 2'd0}) begin
      failures++; $display("FAIL mid_async act=%b/%h/%0d/%0d exp=0000/00/0/0", {ALU_RDY, RF_RDY, W_INC, BUSY}, WR_DATA, WR_CNT, state_dbg);
    end
    tick; RST = 1'b0;
    ALU_OUT = 16'h0F0E; RF_DATA = 8'h99; ALU_VLD = 1'b1; RF_VLD = 1'b1;
    tick; ALU_VLD = 1'b0; RF_VLD = 1'b0; #1;
    checks++;
    if ({ALU_RDY, RF_RDY, W_INC, WR_DATA} !== {3'b101, 8'h0E}) begin
      failures++; $display("FAIL mid_tie act=%b/%h exp=101/0e", {ALU_RDY, RF_RDY, W_INC}, WR_DATA);
    end
    tick; tick; #1;
    exp_q.push_back(8'h0E); exp_q.push_back(8'h0F); exp_cnt = 8'd2;
    checks++;
    if ({BUSY, WR_CNT} !== {1'b0, exp_cnt}) begin
      failures++; $display("FAIL mid_done act=%b/%0d exp=0/%0d", BUSY, WR_CNT, exp_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    RST = 1'b1; tick; RST = 1'b0;
    exp_cnt = 8'd0;
    for (int k = 0; k <= 256; k++) begin
      d = k[7:0];
      RF_VLD = 1'b1; RF_DATA = d;
      tick; RF_VLD = 1'b0; #1;
      checks++;
      if ({RF_RDY, W_INC, WR_DATA} !== {2'b11, d}) begin
        failures++; $display("FAIL wrap_write k=%0d act=%b/%h exp=11/%h", k, {RF_RDY, W_INC}, WR_DATA, d);
      end
      exp_q.push_back(d); exp_cnt = exp_cnt + 8'd1;
      tick; #1;
      if (k >= 254) begin
        checks++;
        if (WR_CNT !== exp_cnt) begin
          failures++; $display("FAIL wrap_cnt k=%0d act=%0d exp=%0d", k, WR_CNT, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_tie;
    test_rf;
    test_alu;
    test_full;
    test_reset_mid;
    test_wrap;
    tick; tick;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL sb_size act=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int n = 0; n < exp_q.size(); n++) begin
        checks++;
        if (got_q[n] !== exp_q[n]) begin
          failures++; $display("FAIL sb_byte idx=%0d act=%h exp=%h", n, got_q[n], exp_q[n]);
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
